data_mem_ctrl: RTL

Parametrised successor to the processor's single-cycle data memory. It holds a word array behind a valid/ready request/response handshake with configurable access latency. It supports RV32 byte, half and word loads and stores with sign or zero extension, an atomic word swap, and alignment and range error reporting. It sits in the memory stage, between the execute-stage address/data and writeback.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/data_mem_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the data memory controller.
//   WORD_W  : data word width (32)
//   op_e    : request operation (LOAD/STORE/SWAP/RSVD)
//   size_e  : access size (BYTE/HALF/WORD/RSVD)
//   state_e : controller FSM state (IDLE/WAIT/RESP)
package mem_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_SWAP  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational lane steering for sub-word accesses.
//   old_word   in  current contents of the addressed word
//   addr_lo    in  byte offset within the word (addr[1:0])
//   size       in  access size
//   is_unsigned in zero-extend (1) or sign-extend (0) loads
//   wdata      in  store data, LSB-aligned
//   load_data  out extended load value
//   store_data out old_word with the addressed lanes replaced by wdata
import mem_pkg::*;

module mem_lane_align (
  input  logic [WORD_W-1:0] old_word,
  input  logic [1:0]        addr_lo,
  input  size_e             size,
  input  logic              is_unsigned,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] store_data
);

  function automatic logic [WORD_W-1:0] load_extend(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        lo,
    input size_e             sz,
    input logic              uns
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [WORD_W-1:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] merge_store(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        lo,
    input size_e             sz,
    input logic [WORD_W-1:0] wd
  );
    logic [WORD_W-1:0] r;
    r = word;
    case (sz)
      SZ_BYTE: r[{lo, 3'b000} +: 8]        = wd[7:0];
      SZ_HALF: r[{lo[1], 4'b0000} +: 16]   = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign load_data  = load_extend(old_word, addr_lo, size, is_unsigned);
  assign store_data = merge_store(old_word, addr_lo, size, wdata);

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-array data memory behind a valid/ready handshake with
// configurable access latency; RV32 byte/half/word loads and stores plus an
// atomic word swap, with alignment, range and reserved-encoding errors.
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_op, req_size         operation and access size
//   req_unsigned             zero-extend loads when 1
//   req_addr, req_wdata      byte address, LSB-aligned write data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       load value / old word, error flag
import mem_pkg::*;

module data_mem_ctrl #(
  parameter int DEPTH    = 128,
  parameter int LATENCY  = 2,
  parameter int INIT_IDX = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_e            state;
  logic [2:0]        cnt;
  op_e               op_p0;
  size_e             size_p0;
  logic              uns_p0;
  logic [WORD_W-1:0] addr_p0;
  logic [WORD_W-1:0] wdata_p0;

  logic              accept;
  logic              commit;
  logic              err;
  logic              we;
  logic [AW-1:0]     widx;
  logic [WORD_W-1:0] old_word;
  logic [WORD_W-1:0] load_val;
  logic [WORD_W-1:0] merged;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rdata_nxt;
  logic [WORD_W-1:0] mem_rd [DEPTH];

  assign accept = (state == ST_IDLE) && req_valid;
  assign commit = (state == ST_WAIT) && (cnt == 3'd0);

  // Stage p0: request capture (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0    <= op_e'(req_op);
      size_p0  <= size_e'(req_size);
      uns_p0   <= req_unsigned;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  assign err = (size_p0 == SZ_RSVD) || (op_p0 == OP_RSVD)
            || ((size_p0 == SZ_HALF) && addr_p0[0])
            || ((size_p0 == SZ_WORD) && (addr_p0[1:0] != 2'b00))
            || ((op_p0 == OP_SWAP) && (size_p0 != SZ_WORD))
            || ({2'b00, addr_p0[31:2]} >= 32'(DEPTH));

  assign widx     = addr_p0[AW+1:2];
  assign old_word = mem_rd[widx];

  mem_lane_align u_align (
    .old_word    (old_word),
    .addr_lo     (addr_p0[1:0]),
    .size        (size_p0),
    .is_unsigned (uns_p0),
    .wdata       (wdata_p0),
    .load_data   (load_val),
    .store_data  (merged)
  );

  // Reset forces IDLE asynchronously, so a pending commit can never fire.
  assign we      = commit && !err && (op_p0 != OP_LOAD) && !rst;
  assign wr_word = (op_p0 == OP_SWAP) ? wdata_p0 : merged;

  always_comb begin
    rdata_nxt = '0;
    if (!err) begin
      case (op_p0)
        OP_LOAD: rdata_nxt = load_val;
        OP_SWAP: rdata_nxt = old_word;
        default: rdata_nxt = '0;
      endcase
    end
  end

  // Word storage: one register per word so each can carry its own
  // elaboration-time initial value; contents survive reset.
  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    logic [WORD_W-1:0] word_q = (INIT_IDX != 0) ? WORD_W'(i) : '0;
    always_ff @(posedge clk) begin
      if (we && (widx == AW'(i))) begin
        word_q <= wr_word;
      end
    end
    assign mem_rd[i] = word_q;
  end

  // Stage p1: control FSM and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cnt       <= 3'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 3'd0) begin
            rsp_rdata <= rdata_nxt;
            rsp_err   <= err;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
